output_port_tx: RTL and testbench
=================================

OUTPUT_PORT_TX -- requirements
Module: output_port_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit (legal range 2..255).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning capture FIFO entries (fixed at 4 in this revision).
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous active-low reset; reset=0 sampled on a rising clk edge resets all state.
REQ-005 Port data_in  input  4  CPU output_data bus, sampled every cycle.
REQ-006 Port tx  output  1  serial line; idle high.
REQ-007 Port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-008 Port fifo_count  output  3  entries currently held, 0..4.
REQ-009 Port overflow  output  1  sticky flag: a captured value was dropped.

Function
REQ-010 The block SHALL hold a 4-bit register last_val; a capture event occurs on any edge where data_in != last_val.
REQ-011 On a capture event, last_val SHALL load data_in at that edge, whether or not the value is stored.
REQ-012 On a capture event with fifo_count < 4, data_in SHALL be written to the FIFO tail at that edge; fifo_count increments by 1 unless a pop occurs in the same cycle.
REQ-013 On a capture event with fifo_count == 4 and no same-cycle pop, the value SHALL be dropped, FIFO contents unchanged, overflow set to 1.
REQ-014 On a capture event with fifo_count == 4 and a same-cycle pop, the push SHALL be accepted; fifo_count stays 4.
REQ-015 A capture event into an empty FIFO SHALL NOT pop that same value in that same cycle; earliest pop is the following edge.
REQ-016 FIFO SHALL be first-in first-out; read/write pointers SHALL wrap modulo 4.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; if fifo_count > 0, pop head into shift register, clear baud counter, go START.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
REQ-020 DATA: tx=shift[bit index] for CLKS_PER_BIT cycles per bit, LSB first, bits 0..3, then go STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles, then go IDLE.
REQ-022 A frame SHALL occupy exactly 6*CLKS_PER_BIT cycles; tx SHALL fall on the first edge after the popping edge.
REQ-023 Back-to-back frames: after STOP, one IDLE cycle (tx=1) SHALL precede the next START, giving a 6*CLKS_PER_BIT+1 cycle frame period.
REQ-024 tx and busy SHALL be registered outputs (no combinational path from data_in).
REQ-025 overflow SHALL remain 1 until reset, independent of later FIFO activity.

Reset
REQ-026 While reset=0 at an edge: tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, last_val=0, pointers=0, baud and bit counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; tx=1 from the next edge; discarded FIFO contents are not transmitted.
REQ-028 A data_in value present during reset SHALL NOT be captured; the first edge with reset=1 compares data_in against last_val=0.
REQ-029 A value equal to 0 after reset SHALL produce no capture event.

Verification (CLKS_PER_BIT=4)
REQ-030 Release reset, hold data_in=0 for 50 cycles -> tx=1, busy=0, fifo_count=0 throughout.
REQ-031 data_in 0->5 for one edge, then held -> fifo_count 1 for one cycle; tx sequence 0,1,0,1,0,1, each held 4 cycles (24 cycles total); busy high exactly 24 cycles.
REQ-032 data_in steps 1,2,3,4,5,6 on six consecutive edges -> first pops immediately; 1 transmitted, 2..5 queued, 6 dropped, overflow=1; frames for 1,2,3,4,5 emitted in order with 25-cycle spacing.
REQ-033 FIFO full (4 entries) and capture on the exact IDLE pop edge -> push accepted, fifo_count stays 4, overflow stays 0.
REQ-034 data_in=A, reset=0 during DATA state bit 2 -> tx=1 next edge, fifo_count=0, busy=0; after release with data_in still A, one frame for A is sent.
REQ-035 data_in toggles 3->3 (no change) then 3->0->3 -> only changes generate frames; transmit order 3,0,3 with no duplicates.

Source files
------------

// File: rtl/output_port_tx.sv
// output_port_tx: watches a 4-bit CPU output bus for changes, queues each new
// value in a 4-entry FIFO and sends it as a serial frame on tx. A frame is one
// start bit (0), four data bits LSB first, then one stop bit (1).
module output_port_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] FULL_CNT  = 3'(FIFO_DEPTH);

  state_t     state, state_nx;
  logic [7:0] baud, baud_nx;
  logic [1:0] bit_idx, bit_idx_nx;
  logic       tx_nx;
  logic       pop;

  logic [3:0] last_val;
  logic [3:0] mem [FIFO_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic [3:0] shift;

  logic       capture, full, push, drop;

  // Capture decode: a change on the bus is queued when there is room. A full
  // FIFO still accepts it if the transmitter frees a slot on the same edge.
  always_comb begin
    capture = (data_in != last_val);
    full    = (fifo_count == FULL_CNT);
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  // Transmit FSM next-state, counters and line value. tx is registered from
  // this, so the line lags the state by one cycle and falls on the edge after
  // the pop.
  always_comb begin
    state_nx   = state;
    baud_nx    = baud;
    bit_idx_nx = bit_idx;
    tx_nx      = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != 3'd0) begin
          pop      = 1'b1;
          baud_nx  = '0;
          state_nx = START;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (baud == BAUD_LAST) begin
          baud_nx    = '0;
          bit_idx_nx = '0;
          state_nx   = DATA;
        end else begin
          baud_nx = baud + 8'd1;
        end
      end
      DATA: begin
        tx_nx = shift[bit_idx];
        if (baud == BAUD_LAST) begin
          baud_nx = '0;
          if (bit_idx == 2'd3) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 2'd1;
          end
        end else begin
          baud_nx = baud + 8'd1;
        end
      end
      STOP: begin
        tx_nx = 1'b1;
        if (baud == BAUD_LAST) begin
          baud_nx  = '0;
          state_nx = IDLE;
        end else begin
          baud_nx = baud + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, bit timing and registered line outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      tx      <= tx_nx;
      busy    <= (state != IDLE);
    end
  end

  // FIFO bookkeeping, change detector and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_val   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (capture) last_val <= data_in;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop) begin
        fifo_count <= fifo_count + 3'd1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 3'd1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // FIFO storage and transmit shift register; contents are only meaningful
  // while the pointers say so, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
    if (pop) shift <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_output_port_tx.sv
// Bench for output_port_tx: directed scenarios followed by random bus activity,
// compared every cycle against a queue-based reference model, plus a serial
// line decoder that recovers transmitted values for the directed scenarios.
module tb_output_port_tx;

  localparam int CPB          = 4;
  localparam int FIFO_ENTRIES = 4;
  localparam int AGE_IDLE     = 1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_in = 4'hA;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  output_port_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FIFO_ENTRIES)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: pending values, last seen bus value, sticky drop flag,
  // and the number of edges since the current frame's value was popped.
  logic [3:0] m_q[$];
  logic [3:0] m_last = 4'h0;
  logic       m_ovf = 1'b0;
  logic [3:0] m_val = 4'h0;
  int         m_age = AGE_IDLE;

  // Values recovered from the serial line.
  logic [3:0] rx_q[$];
  logic [3:0] want[$];
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [3:0] rx_bits = 4'h0;

  // Line decoder: a frame starts at the first low sample; each data bit is
  // sampled mid-bit and shifted in LSB first.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      rx_on <= 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  <= 1'b1;
        rx_cnt <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (((rx_cnt + 1) % CPB) == (CPB / 2) && (rx_cnt + 1) >= CPB && (rx_cnt + 1) < 5 * CPB)
        rx_bits <= {tx, rx_bits[3:1]};
      if ((rx_cnt + 1) == 6 * CPB - 1) begin
        rx_on <= 1'b0;
        rx_q.push_back(rx_bits);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pop_next();
    return (m_age >= 6 * CPB) && (m_q.size() > 0);
  endfunction

  task automatic model_edge(input logic rst_n, input logic [3:0] d);
    bit do_pop;
    if (!rst_n) begin
      m_q.delete();
      m_last = 4'h0;
      m_ovf  = 1'b0;
      m_age  = AGE_IDLE;
      return;
    end
    do_pop = pop_next();
    if (do_pop) begin
      m_val = m_q.pop_front();
      m_age = 0;
    end else if (m_age < AGE_IDLE) begin
      m_age++;
    end
    if (d != m_last) begin
      m_last = d;
      if (m_q.size() < FIFO_ENTRIES) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  // Expected line after an edge: the frame occupies edges 1..6*CPB after the
  // pop, split into start, four data bits and stop, CPB cycles each.
  task automatic expect_line(output logic e_tx, output logic e_busy);
    int p;
    int seg;
    e_tx   = 1'b1;
    e_busy = 1'b0;
    if (m_age >= 1 && m_age <= 6 * CPB) begin
      p      = m_age - 1;
      seg    = p / CPB;
      e_busy = 1'b1;
      if (seg == 0) e_tx = 1'b0;
      else if (seg <= 4) e_tx = m_val[seg-1];
      else e_tx = 1'b1;
    end
  endtask

  task automatic tick(input logic rst_n, input logic [3:0] d);
    logic e_tx;
    logic e_busy;
    reset   = rst_n;
    data_in = d;
    @(posedge clk);
    model_edge(rst_n, d);
    #1;
    expect_line(e_tx, e_busy);
    chk("tx", {31'b0, tx}, {31'b0, e_tx});
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("fifo_count", {29'b0, fifo_count}, 32'(m_q.size()));
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_frames"}, 32'(rx_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++)
      if (i < rx_q.size()) chk(tag, {28'b0, rx_q[i]}, {28'b0, want[i]});
  endtask

  initial begin
    int busy_cycles;
    int guard;
    logic [3:0] d;
    logic       rst_v;

    // Reset with a nonzero bus value that must not be captured.
    for (int i = 0; i < 3; i++) tick(1'b0, 4'hA);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_count", {29'b0, fifo_count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // Quiet bus at zero after reset: nothing is sent.
    for (int i = 0; i < 50; i++) tick(1'b1, 4'h0);
    chk("quiet_count", {29'b0, fifo_count}, 32'd0);

    // Single change 0 -> 5: one frame, busy for exactly one frame length.
    rx_q.delete();
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 4'h5);
      if (busy === 1'b1) busy_cycles++;
    end
    chk("single_busy_cycles", 32'(busy_cycles), 32'(6 * CPB));
    want = '{4'h5};
    check_rx("single_rx");

    // Burst 1..6 on consecutive edges: 6 is dropped, 1..5 go out in order.
    rx_q.delete();
    for (int v = 1; v <= 6; v++) tick(1'b1, 4'(v));
    chk("burst_ovf", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 135; i++) tick(1'b1, 4'h6);
    want = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    check_rx("burst_rx");
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Clear the sticky flag, then fill the FIFO and capture on the pop edge.
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h0);
    rx_q.delete();
    tick(1'b1, 4'h7);
    tick(1'b1, 4'h8);
    tick(1'b1, 4'h9);
    tick(1'b1, 4'hA);
    tick(1'b1, 4'hB);
    chk("full_count", {29'b0, fifo_count}, 32'd4);
    guard = 0;
    while (!pop_next() && guard < 200) begin
      tick(1'b1, 4'hB);
      guard++;
    end
    chk("pop_edge_found", 32'(guard < 200), 32'd1);
    tick(1'b1, 4'hC);
    chk("pop_push_count", {29'b0, fifo_count}, 32'd4);
    chk("pop_push_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 150; i++) tick(1'b1, 4'hC);
    want = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    check_rx("pop_push_rx");

    // Reset in the middle of data bit 2 aborts the frame; A is resent after.
    tick(1'b0, 4'h0);
    tick(1'b1, 4'hA);
    tick(1'b1, 4'hA);
    for (int i = 0; i < 13; i++) tick(1'b1, 4'hA);
    tick(1'b0, 4'hA);
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_count", {29'b0, fifo_count}, 32'd0);
    rx_q.delete();
    for (int i = 0; i < 40; i++) tick(1'b1, 4'hA);
    want = '{4'hA};
    check_rx("abort_rx");

    // Repeated value makes no frame: 3,3,0,3 sends 3,0,3.
    tick(1'b0, 4'h0);
    rx_q.delete();
    tick(1'b1, 4'h3);
    tick(1'b1, 4'h3);
    tick(1'b1, 4'h0);
    for (int i = 0; i < 90; i++) tick(1'b1, 4'h3);
    want = '{4'h3, 4'h0, 4'h3};
    check_rx("repeat_rx");

    // Random bus activity with occasional resets.
    d = 4'h3;
    for (int i = 0; i < 600; i++) begin
      rst_v = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2) == 0) d = 4'($urandom_range(0, 15));
      tick(rst_v, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
